// File: rtl/aes_ctr_framer.sv
// rtl/aes_ctr_framer.sv - serializes key, IV and payload into the AES-256 CTR core input stream
// Optional feature macro: AES_CTR_FRAMER_STATS_EN (adds stat_pkt_cnt_o / stat_byte_cnt_o).
`timescale 1ns/1ps
module aes_ctr_framer #(
  parameter int unsigned AXIS_WIDTH = 64,
  parameter int unsigned KEY_LENGTH = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [KEY_LENGTH-1:0]   cfg_key_i,
  input  logic [127:0]            cfg_iv_i,
  input  logic                    cfg_encrypt_i,
  input  logic [AXIS_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [AXIS_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                    s_axis_tlast_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  output logic [AXIS_WIDTH-1:0]   m_axis_tdata_o,
  output logic [AXIS_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                    m_axis_tlast_o,
  output logic                    m_axis_tuser_o,
  output logic                    m_axis_tvalid_o,
  input  logic                    m_axis_tready_i,
  output logic                    proto_err_o
`ifdef AES_CTR_FRAMER_STATS_EN
  ,
  output logic [31:0]             stat_pkt_cnt_o,
  output logic [31:0]             stat_byte_cnt_o
`endif
);

  localparam int unsigned KEEP_W    = AXIS_WIDTH / 8;
  localparam int unsigned KEY_WORDS = KEY_LENGTH / AXIS_WIDTH;
  localparam int unsigned IV_WORDS  = 128 / AXIS_WIDTH;
  localparam int unsigned CNT_W     = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_KEY     = 4'b0010;
  localparam logic [3:0] ST_IV      = 4'b0100;
  localparam logic [3:0] ST_PAYLOAD = 4'b1000;

  logic [3:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [KEY_LENGTH-1:0] key_q, key_d;
  logic [127:0]          iv_q, iv_d;
  logic                  enc_q, enc_d;
  logic                  proto_err_q, proto_err_d;

  logic cfg_fire, m_fire, pay_fire;
  logic keep_full, keep_contig, beat_bad;

  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign m_fire      = m_axis_tvalid_o & m_axis_tready_i;
  assign pay_fire    = (state_q == ST_PAYLOAD) & m_fire;
  assign keep_full   = &s_axis_tkeep_i;
  // tkeep of the form 0..01..1 has no set bit above a clear one: k & (k+1) == 0
  assign keep_contig = ((s_axis_tkeep_i & (s_axis_tkeep_i + KEEP_W'(1))) == '0);
  assign beat_bad    = (~s_axis_tlast_i & ~keep_full) | ~keep_contig | (s_axis_tkeep_i == '0);
  assign proto_err_o = proto_err_q;

  // Output stream mux: framing words from latched registers, payload passes straight through
  always_comb begin
    cfg_ready_o     = 1'b0;
    s_axis_tready_o = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = '0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = 1'b0;
    case (state_q)
      ST_IDLE: cfg_ready_o = rst_n_i;
      ST_KEY: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = AXIS_WIDTH'(key_q >> (32'(cnt_q) * AXIS_WIDTH));
        m_axis_tkeep_o  = '1;
        m_axis_tuser_o  = enc_q;
      end
      ST_IV: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = AXIS_WIDTH'(iv_q >> (32'(cnt_q) * AXIS_WIDTH));
        m_axis_tkeep_o  = '1;
        m_axis_tuser_o  = enc_q;
      end
      ST_PAYLOAD: begin
        m_axis_tvalid_o = s_axis_tvalid_i;
        s_axis_tready_o = m_axis_tready_i;
        m_axis_tdata_o  = s_axis_tdata_i;
        m_axis_tkeep_o  = s_axis_tkeep_i;
        m_axis_tlast_o  = s_axis_tlast_i;
        m_axis_tuser_o  = enc_q;
      end
      default: ;
    endcase
  end

  // Next-state: descriptor latch, word counting through key and IV, exit on payload tlast
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    iv_d        = iv_q;
    enc_d       = enc_q;
    proto_err_d = proto_err_q | (pay_fire & beat_bad);
    case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          key_d   = cfg_key_i;
          iv_d    = cfg_iv_i;
          enc_d   = cfg_encrypt_i;
          cnt_d   = '0;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        if (m_fire) begin
          if (cnt_q == CNT_W'(KEY_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = ST_IV;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_IV: begin
        if (m_fire) begin
          if (cnt_q == CNT_W'(IV_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (pay_fire & s_axis_tlast_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any packet in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      iv_q        <= '0;
      enc_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      enc_q       <= enc_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef AES_CTR_FRAMER_STATS_EN
  logic [31:0] pkt_cnt_q, byte_cnt_q, keep_pop;

  // Number of valid bytes in the current payload beat
  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KEEP_W; i++) keep_pop = keep_pop + 32'(s_axis_tkeep_i[i]);
  end

  // Packet and byte counters, free-running modulo 2^32
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (pay_fire) begin
      byte_cnt_q <= byte_cnt_q + keep_pop;
      if (s_axis_tlast_i) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign stat_pkt_cnt_o  = pkt_cnt_q;
  assign stat_byte_cnt_o = byte_cnt_q;
`endif

endmodule

// File: doc/aes_ctr_framer.md
Name: aes_ctr_framer

Overview:
- Upstream feeder for the AES-256 CTR iterative core.
- Takes one per-packet descriptor (key, IV, encrypt flag) on a valid/ready side channel and a payload stream on AXI-Stream.
- Emits the serialized stream the core consumes on its slave port: key words, then IV words, then payload words ending in tlast.
- One descriptor per packet; the core reloads its key every packet.

Parameters:
- AXIS_WIDTH, 64, tdata width of both streams (64 or 128; must divide 128).
- KEY_LENGTH, 256, key width in bits (`AES256_KEY_LENGTH).

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- Cfg_valid  in  1  descriptor valid.
- Cfg_ready  out  1  descriptor accepted when Cfg_valid & Cfg_ready.
- Cfg_key  in  KEY_LENGTH  key; word k = Cfg_key[k*AXIS_WIDTH +: AXIS_WIDTH].
- Cfg_iv  in  128  initial counter block; byte i at Cfg_iv[8i +: 8], byte 0 is the first wire byte.
- Cfg_encrypt  in  1  driven on tuser for every beat of the packet.
- S_axis  axis_if.slave  AXIS_WIDTH  payload in (tdata, tkeep, tlast, tvalid, tready).
- M_axis  axis_if.master  AXIS_WIDTH  framed stream to the CTR core; tuser is the encrypt flag.
- Proto_err  out  1  sticky payload protocol-violation flag.

Behaviour:
- States (one-hot): ST_IDLE, ST_KEY, ST_IV, ST_PAYLOAD.
- Reset (Rst_n low, asynchronous):
  - State goes to ST_IDLE; word counter, key/IV/encrypt registers and Proto_err clear to 0.
  - Cfg_ready, M_axis.tvalid, M_axis.tlast and S_axis.tready are 0 while reset is asserted.
  - Reset mid-packet abandons the packet with no flush; the next packet starts with a new descriptor.
- ST_IDLE:
  - Cfg_ready=1, M_axis.tvalid=0, S_axis.tready=0.
  - On a Cfg handshake, latch key, IV and encrypt, clear the word counter, go to ST_KEY.
- ST_KEY:
  - M_axis.tvalid=1, tdata = key word[cnt], tkeep all ones, tlast=0, tuser = latched encrypt.
  - Counter advances only on M_axis.tvalid & tready; tdata holds stable while stalled.
  - After word KEY_LENGTH/AXIS_WIDTH-1 is accepted, clear the counter and go to ST_IV.
- ST_IV:
  - Same beat rules as ST_KEY; tdata = Cfg_iv word[cnt], for 128/AXIS_WIDTH words.
  - After the last IV word is accepted, go to ST_PAYLOAD.
- ST_PAYLOAD: zero-latency combinational pass-through.
  - M_axis.tvalid = S_axis.tvalid; S_axis.tready = M_axis.tready.
  - tdata, tkeep and tlast are copied; tuser = latched encrypt.
  - When the beat with tlast is accepted, go to ST_IDLE. The next Cfg handshake is possible one cycle later, at the earliest.
- Cfg_ready=0 and S_axis.tready=0 in every state except where stated above.
- No bubbles between key, IV and payload beats when the sink holds tready=1.
  - A 64-bit packet of P payload beats occupies 1 + 4 + 2 + P cycles including the idle cycle.
- Proto_err is set, sticky until reset, on an accepted payload beat that has:
  - tlast=0 and tkeep not all ones, or
  - tkeep not of the form {0..0,1..1}, or
  - tkeep == 0.
  The offending beat is still forwarded unchanged.
- Cfg_valid asserted outside ST_IDLE is ignored and not acknowledged. Cfg inputs are sampled only on the handshake cycle.

Optional Feature:
- Macro: AES_CTR_FRAMER_STATS_EN.
- When defined, add outputs Stat_pkt_cnt[31:0] and Stat_byte_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - Stat_pkt_cnt increments when a payload tlast beat is accepted.
  - Stat_byte_cnt adds popcount(tkeep) on every accepted payload beat, in the same cycle.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic framing (AXIS_WIDTH=64):
  - Stimulus: Cfg_key byte i = i, Cfg_iv byte i = 0xF0+i, encrypt=1; 2-beat payload 64'h1111..., 64'h2222... with tlast, tkeep=8'hFF; sink always ready.
  - Response: M beats 64'h0706050403020100, ..0F0E0D0C0B0A0908, ..1716151413121110, ..1F1E1D1C1B1A1918, 64'hF7F6F5F4F3F2F1F0, 64'hFFFEFDFCFBFAF9F8, 64'h1111..., 64'h2222... with tlast on the last beat only; tuser=1 throughout; 8 consecutive cycles.
- Backpressure: random M_axis.tready at 50%.
  - Response: identical beat sequence; tdata/tlast stable during stalls; no S_axis beat accepted before the 6th framing beat completes.
- Partial last beat: payload 3 beats, last with tkeep=8'h07.
  - Response: forwarded unchanged; Proto_err stays 0; back to ST_IDLE with Cfg_ready=1 one cycle after the tlast handshake.
- Protocol error: non-last payload beat with tkeep=8'h0F.
  - Response: beat forwarded; Proto_err=1 from the next cycle and stays 1 across the next packet.
- Reset mid-IV: Rst_n low for 1 cycle after the 5th beat.
  - Response: M_axis.tvalid=0 immediately (asynchronous); the next descriptor restarts at key word 0.
- Stats (AES_CTR_FRAMER_STATS_EN): two packets of 19 and 8 bytes.
  - Response: Stat_pkt_cnt=2, Stat_byte_cnt=27.
